led_scan_controller: RTL and testbench
======================================

LED_SCAN_CONTROLLER -- requirements
Module: led_scan_controller

Interface
REQ-001 Parameter N, default 8: Conway grid / LED array edge size.
REQ-002 Parameter DWELL, default 1000: cycles each column is driven (ena=1).
REQ-003 Parameter BLANK, default 2: cycles ena=0 before each column, for ghosting suppression.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  1 = scan array; 0 = return to IDLE.
REQ-007 cells_in  input  N*N  new frame, row-major (bit r*N+c = row r, column c).
REQ-008 cells_valid  input  1  cells_in holds a frame offered for display.
REQ-009 cells_ready  output  1  controller accepts cells_in this cycle.
REQ-010 disp_cells  output  N*N  latched frame driven to the array driver's cells input.
REQ-011 x  output  $clog2(N)  current column index to the driver.
REQ-012 ena  output  1  column-decoder enable to the driver.
REQ-013 frame_done  output  1  one-cycle pulse when a full N-column scan completes.

Function
REQ-014 The block SHALL implement states IDLE, BLANK and DRIVE, with a shared down-counter of width $clog2(max(DWELL,BLANK)+1).
REQ-015 IDLE: ena=0, x=0; the block SHALL go to BLANK with counter=BLANK-1 on the first cycle enable=1.
REQ-016 BLANK: ena=0, x held; at counter=0 the block SHALL go to DRIVE with counter=DWELL-1, else decrement.
REQ-017 DRIVE: ena=1, x held; at counter=0 the block SHALL increment x and go to BLANK with counter=BLANK-1, else decrement.
REQ-018 x SHALL wrap from N-1 to 0; frame_done SHALL be 1 exactly in the cycle after the DRIVE->BLANK transition that wraps x, else 0.
REQ-019 The frame period SHALL be exactly N*(BLANK+DWELL) cycles; column k SHALL see ena=1 for exactly DWELL consecutive cycles.
REQ-020 cells_ready SHALL be 1 in IDLE and in BLANK when x=0, else 0 (tear-free: frame swaps only while the array is dark, before column 0).
REQ-021 When cells_valid=1 and cells_ready=1 on a rising edge, disp_cells SHALL load cells_in; disp_cells SHALL be held at all other times.
REQ-022 cells_valid while cells_ready=0 SHALL NOT be consumed; the source holds cells_in until the transfer occurs.
REQ-023 enable=0 sampled in any state SHALL force IDLE next cycle (ena=0, x=0, counter=0, no frame_done), regardless of counter value; disp_cells is retained.
REQ-024 ena SHALL never be 1 in the same cycle disp_cells changes.
REQ-025 Elaboration SHALL $error if N<1, N>8, DWELL<1 or BLANK<1.

Reset
REQ-026 rst_n=0 SHALL immediately (no clock) force IDLE, x=0, ena=0, counter=0, disp_cells=0, cells_ready=0, frame_done=0.
REQ-027 After rst_n rises, cells_ready SHALL be 1 from the first clock edge (IDLE); scanning SHALL begin only on enable=1.

Verification (N=8, DWELL=4, BLANK=2)
REQ-028 Reset, enable=1 -> ena pattern 0,0,1,1,1,1 per column; x=0..7; x wraps to 0 and frame_done pulses once after 48 cycles, repeating every 48.
REQ-029 cells_valid=1, cells_in=64'h0123456789ABCDEF in IDLE -> accepted on that edge; disp_cells=64'h0123456789ABCDEF next cycle.
REQ-030 During scan, cells_valid=1 with 64'hFF00FF00FF00FF00 raised while x=3 -> cells_ready stays 0 until BLANK with x=0; disp_cells changes only then, ena=0 at that cycle.
REQ-031 enable dropped mid-DRIVE at x=5, counter=2 -> next cycle IDLE, ena=0, x=0, no frame_done; re-enable restarts with 2 blank cycles at x=0.
REQ-032 rst_n pulsed low mid-DRIVE at x=6 between clock edges -> ena, x, disp_cells, frame_done read 0 before the next edge.

Source files
------------

// File: rtl/led_scan_controller.sv
// LED column-scan controller: walks an N-column LED array one column at a time.
// Each column gets BLANK dark cycles followed by DWELL lit cycles.
// A new frame is latched only while the array is dark, just before column 0.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | not scanning; ena=0, x=0; frame accepted at any time
// BLANK  | column x dark for BLANK cycles (ghosting suppression)
// DRIVE  | column x lit for DWELL cycles; then advance x, wrap N-1 -> 0
module led_scan_controller #(
  parameter int N     = 8,
  parameter int DWELL = 1000,
  parameter int BLANK = 2,
  localparam int XW   = (N > 1) ? $clog2(N) : 1,
  localparam int CW   = $clog2(((DWELL > BLANK) ? DWELL : BLANK) + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [N*N-1:0]  cells_in,
  input  logic            cells_valid,
  output logic            cells_ready,
  output logic [N*N-1:0]  disp_cells,
  output logic [XW-1:0]   x,
  output logic            ena,
  output logic            frame_done
);

  if (N < 1 || N > 8 || DWELL < 1 || BLANK < 1) begin : g_bad_param
    $error("led_scan_controller: illegal parameters N=%0d DWELL=%0d BLANK=%0d",
           N, DWELL, BLANK);
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_e;

  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(N - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XW-1:0]   x_q, x_d;
  logic            ready_q, ready_d;
  logic            frame_done_q, frame_done_d;
  logic [N*N-1:0]  disp_q, disp_d;
  logic            load;

  // Next-state, shared dwell/blank down-counter and column advance.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    frame_done_d = 1'b0;
    if (!enable) begin
      // Dropping enable abandons the scan at once, whatever the counter says.
      state_d = S_IDLE;
      cnt_d   = '0;
      x_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          cnt_d   = BLANK_LD;
          x_d     = '0;
        end
        S_BLANK: begin
          if (cnt_q == '0) begin
            state_d = S_DRIVE;
            cnt_d   = DWELL_LD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_DRIVE: begin
          if (cnt_q == '0) begin
            state_d = S_BLANK;
            cnt_d   = BLANK_LD;
            if (x_q == X_LAST) begin
              x_d          = '0;
              frame_done_d = 1'b1;
            end else begin
              x_d = x_q + XW'(1);
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          x_d     = '0;
        end
      endcase
    end
  end

  // Ready is registered from the next state so it is 0 during reset and rises
  // on the first edge afterwards; frame swaps only in IDLE or dark column 0.
  always_comb begin
    ready_d = (state_d == S_IDLE) || ((state_d == S_BLANK) && (x_d == '0));
    load    = cells_valid && ready_q;
    disp_d  = load ? cells_in : disp_q;
  end

  // State, counter, column, handshake and frame registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      x_q          <= '0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
      disp_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
      disp_q       <= disp_d;
    end
  end

  // Outputs come straight from registers so reset clears them without a clock.
  always_comb begin
    ena         = (state_q == S_DRIVE);
    x           = x_q;
    cells_ready = ready_q;
    frame_done  = frame_done_q;
    disp_cells  = disp_q;
  end

endmodule

// File: tb/tb_led_scan_controller.sv
// Bench for led_scan_controller (N=8, DWELL=4, BLANK=2).
// Reference model counts cycles since the scan started and derives column,
// phase and frame boundaries arithmetically.
module tb_led_scan_controller;
  localparam int N     = 8;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int PER   = BLANK + DWELL;
  localparam int FRAME = N * PER;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        cells_valid = 1'b0;
  logic [63:0] cells_in = '0;
  logic        cells_ready;
  logic [63:0] disp_cells;
  logic [2:0]  x;
  logic        ena;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  led_scan_controller #(.N(N), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cells_in    (cells_in),
    .cells_valid (cells_valid),
    .cells_ready (cells_ready),
    .disp_cells  (disp_cells),
    .x           (x),
    .ena         (ena),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_started = 1'b0;
  bit          m_idle = 1'b1;
  bit          m_last_load = 1'b0;
  int          m_k = 0;
  logic [63:0] m_disp = '0;

  function automatic bit m_ready();
    return m_started && (m_idle || ((((m_k / PER) % N) == 0) && ((m_k % PER) < BLANK)));
  endfunction
  function automatic bit exp_ena();
    return !m_idle && ((m_k % PER) >= BLANK);
  endfunction
  function automatic int exp_x();
    return m_idle ? 0 : ((m_k / PER) % N);
  endfunction
  function automatic bit exp_fd();
    return !m_idle && (m_k > 0) && ((m_k % FRAME) == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started   = 1'b0;
      m_idle      = 1'b1;
      m_k         = 0;
      m_disp      = '0;
      m_last_load = 1'b0;
    end else begin
      m_last_load = cells_valid && m_ready();
      if (m_last_load) m_disp = cells_in;
      if (!enable) begin
        m_idle = 1'b1;
        m_k    = 0;
      end else if (m_idle) begin
        m_idle = 1'b0;
        m_k    = 0;
      end else begin
        m_k++;
      end
      m_started = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("ena", 64'(ena), 64'(exp_ena()));
    check("x", 64'(x), 64'(exp_x()));
    check("frame_done", 64'(frame_done), 64'(exp_fd()));
    check("cells_ready", 64'(cells_ready), 64'(m_ready()));
    check("disp_cells", disp_cells, m_disp);
  end

  task automatic wait_x_ena(input logic [2:0] xv, input logic enav, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (x == xv && ena == enav) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, " wait"}, 64'(ok), 64'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [5:0]  pat;
    int          fd1, fd2, nfd;
    logic [2:0]  prev_x;
    logic        prev_ena, prev_rdy;
    bit          seen;

    // Reset asserted asynchronously, checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("reset cells_ready", 64'(cells_ready), 64'd0);
    check("reset disp_cells", disp_cells, 64'd0);
    check("reset ena", 64'(ena), 64'd0);
    check("reset x", 64'(x), 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Ready from the first edge after reset.
    @(negedge clk);
    check("ready after reset", 64'(cells_ready), 64'd1);

    // Frame accepted in IDLE.
    #1 cells_valid = 1'b1; cells_in = 64'h0123456789ABCDEF;
    @(negedge clk);
    check("idle load", disp_cells, 64'h0123456789ABCDEF);
    #1 cells_valid = 1'b0; enable = 1'b1;

    // Column timing and frame period.
    pat = 6'b111100;
    fd1 = -1; fd2 = -1; nfd = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i <= 6) check("col0 ena pattern", 64'(ena), 64'(pat[i-1]));
      if (i == 7) check("col1 x", 64'(x), 64'd1);
      if (frame_done) begin
        nfd++;
        if (fd1 < 0) fd1 = i;
        else if (fd2 < 0) fd2 = i;
      end
    end
    check("first frame_done sample", 64'(fd1), 64'd49);
    check("frame period", 64'(fd2 - fd1), 64'd48);
    check("frame_done pulses", 64'(nfd), 64'd2);

    // Frame offered mid-scan waits for dark column 0.
    wait_x_ena(3'd3, 1'b0, "x3");
    prev_x = x; prev_ena = ena; prev_rdy = cells_ready;
    #1 cells_valid = 1'b1; cells_in = 64'hFF00FF00FF00FF00;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (disp_cells == 64'hFF00FF00FF00FF00) begin
        seen = 1'b1;
        break;
      end
      prev_x = x; prev_ena = ena; prev_rdy = cells_ready;
    end
    check("tear-free load seen", 64'(seen), 64'd1);
    check("load cycle x", 64'(prev_x), 64'd0);
    check("load cycle ena", 64'(prev_ena), 64'd0);
    check("load cycle ready", 64'(prev_rdy), 64'd1);
    #1 cells_valid = 1'b0;

    // Enable dropped in DRIVE at x=5 with counter=2.
    wait_x_ena(3'd5, 1'b1, "x5 drive");
    @(negedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    check("abort ena", 64'(ena), 64'd0);
    check("abort x", 64'(x), 64'd0);
    check("abort frame_done", 64'(frame_done), 64'd0);
    check("abort ready", 64'(cells_ready), 64'd1);
    #1 enable = 1'b1;
    pat = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("restart ena", 64'(ena), 64'(pat[i]));
      check("restart x", 64'(x), 64'd0);
    end

    // Asynchronous reset mid-DRIVE at x=6.
    wait_x_ena(3'd6, 1'b1, "x6 drive");
    #2 rst_n = 1'b0;
    #1;
    check("async rst ena", 64'(ena), 64'd0);
    check("async rst x", 64'(x), 64'd0);
    check("async rst disp", disp_cells, 64'd0);
    check("async rst frame_done", 64'(frame_done), 64'd0);
    check("async rst ready", 64'(cells_ready), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (cells_valid && m_last_load) cells_valid = 1'b0;
      if (!cells_valid && $urandom_range(0, 4) == 0) begin
        cells_valid = 1'b1;
        cells_in    = {$urandom, $urandom};
      end
      if (enable) begin
        if ($urandom_range(0, 149) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        enable = 1'b1;
      end
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
